ex_muldiv: RTL



---
 rtl/cpu_pkg.sv | 15 +
 rtl/md_step.sv | 32 +++
 rtl/ex_muldiv.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: multiply/divide op encodings and the muldiv FSM states.
package cpu_pkg;

   localparam logic [1:0] MD_MULTU = 2'd0;
   localparam logic [1:0] MD_MULT  = 2'd1;
   localparam logic [1:0] MD_DIVU  = 2'd2;
   localparam logic [1:0] MD_DIV   = 2'd3;

   typedef enum logic [1:0] {
      MD_IDLE  = 2'd0,
      MD_CALC  = 2'd1,
      MD_FIXUP = 2'd2
   } md_state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of the iterative mul/div datapath: shift-add multiply or
// restoring trial-subtract divide on a 2*WIDTH accumulator.
module md_step #(
   parameter int WIDTH = 32
) (
   input  logic               i_is_div,
   input  logic [2*WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0]   i_operand,
   output logic [2*WIDTH-1:0] o_acc
);

   logic [WIDTH:0] w_sum;
   logic [WIDTH:0] w_trial;

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
   // Divide:   acc = {remainder, remaining dividend / quotient bits}, shifted left.
   // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
   always_comb begin
      w_sum   = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
      w_trial = {i_acc[2*WIDTH-1:WIDTH], i_acc[WIDTH-1]} - {1'b0, i_operand};
      if (i_is_div) begin
         if (w_trial[WIDTH]) begin
            o_acc = {i_acc[2*WIDTH-2:0], 1'b0};
         end else begin
            o_acc = {w_trial[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
         end
      end else begin
         o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; signs are re-applied in a single FIXUP cycle.
module ex_muldiv
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             CLOCK,
   input  logic             RESET,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   md_state_e          r_state, w_next_state;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_is_div, r_sign_a, r_sign_b, r_div_zero;
   logic [2*WIDTH-1:0] r_acc, w_step_acc;
   logic [WIDTH-1:0]   r_operand;
   logic [WIDTH-1:0]   r_hi, r_lo;
   logic               r_done;

   logic               w_accept, w_signed, w_div, w_sign_a, w_sign_b, w_neg;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quot, w_rem, w_quot_fix, w_rem_fix, w_fix_hi, w_fix_lo;

   always_comb begin
      w_accept = start & ~flush & (r_state == MD_IDLE);
      w_signed = (op == MD_MULT) || (op == MD_DIV);
      w_div    = (op == MD_DIVU) || (op == MD_DIV);
      w_sign_a = w_signed & op_a[WIDTH-1];
      w_sign_b = w_signed & op_b[WIDTH-1];
      w_mag_a  = w_sign_a ? -op_a : op_a;
      w_mag_b  = w_sign_b ? -op_b : op_b;
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) r_state <= MD_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         MD_IDLE:  if (w_accept) w_next_state = MD_CALC;
         MD_CALC: begin
            if (flush)                   w_next_state = MD_IDLE;
            else if (r_cnt == LAST_ITER) w_next_state = MD_FIXUP;
         end
         MD_FIXUP: w_next_state = MD_IDLE;
         default:  w_next_state = MD_IDLE;
      endcase
   end

   md_step #(.WIDTH(WIDTH)) u_step (
      .i_is_div  (r_is_div),
      .i_acc     (r_acc),
      .i_operand (r_operand),
      .o_acc     (w_step_acc)
   );

   // Multiply seeds the accumulator with |op_b| and adds |op_a|; divide seeds
   // it with |op_a| and subtracts |op_b|.
   // NOTE: datapath registers are reset too, so a mid-operation reset leaves no stale state.
   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_cnt      <= '0;
         r_is_div   <= 1'b0;
         r_sign_a   <= 1'b0;
         r_sign_b   <= 1'b0;
         r_div_zero <= 1'b0;
         r_acc      <= '0;
         r_operand  <= '0;
      end else if (w_accept) begin
         r_cnt      <= '0;
         r_is_div   <= w_div;
         r_sign_a   <= w_sign_a;
         r_sign_b   <= w_sign_b;
         r_div_zero <= (op_b == '0);
         r_acc      <= {{WIDTH{1'b0}}, (w_div ? w_mag_a : w_mag_b)};
         r_operand  <= w_div ? w_mag_b : w_mag_a;
      end else if (r_state == MD_CALC) begin
         r_acc <= w_step_acc;
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Divide by zero leaves the dividend magnitude in the remainder, so the
   // remainder sign fixup already restores op_a; only the quotient is forced.
   always_comb begin
      w_neg      = r_sign_a ^ r_sign_b;
      w_prod_fix = w_neg ? -r_acc : r_acc;
      w_quot     = r_acc[WIDTH-1:0];
      w_rem      = r_acc[2*WIDTH-1:WIDTH];
      w_quot_fix = r_div_zero ? '1 : (w_neg ? -w_quot : w_quot);
      w_rem_fix  = r_sign_a ? -w_rem : w_rem;
      w_fix_hi   = r_is_div ? w_rem_fix  : w_prod_fix[2*WIDTH-1:WIDTH];
      w_fix_lo   = r_is_div ? w_quot_fix : w_prod_fix[WIDTH-1:0];
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         r_hi   <= '0;
         r_lo   <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == MD_FIXUP) && !flush;
         if ((r_state == MD_FIXUP) && !flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
         end else if (r_state == MD_IDLE) begin
            if (hi_we) r_hi <= wdata;
            if (lo_we) r_lo <= wdata;
         end
      end
   end

   assign hi    = r_hi;
   assign lo    = r_lo;
   assign busy  = (r_state != MD_IDLE);
   assign done  = r_done;
   assign stall = busy | w_accept;

endmodule
